id_ex_stage: RTL

ID/EX pipeline stage of the LEGv8 pipeline: sits directly downstream of the register file, capturing its two asynchronous read ports plus decode outputs into the EX-stage register. Includes same-cycle writeback bypass, because the register file writes on the clock edge and a read during that cycle returns the old value. Also includes XZR forcing, load-use hazard detection with bubble insertion, external stall and flush.

---
 rtl/legv8_pkg.sv | 15 +
 rtl/id_ex_hazard.sv | 24 ++
 rtl/id_ex_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 types and constants for the ID/EX pipeline slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package legv8_pkg;

    // Register index that always reads as zero and is never written.
    localparam logic [4:0] XZR_IDX = 5'd31;

    // Width of the opaque EX/MEM/WB control bundle unless overridden.
    localparam int CTRL_W_DEFAULT = 16;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [63:0] dword_t;

endpackage : legv8_pkg

// File: rtl/id_ex_hazard.sv
// Load-use detector: flags an ID instruction that reads the destination of a load sitting in EX.
// Latency: purely combinational, no register stage.
// Backpressure: hazard_stall asks PC/IF/ID to hold; a bubble in EX never raises it.
module id_ex_hazard
    import legv8_pkg::*;
#(
    parameter reg_idx_t XZR = XZR_IDX
) (
    input  logic     ex_valid,
    input  logic     ex_mem_read,
    input  reg_idx_t ex_rd,
    input  logic     id_valid,
    input  reg_idx_t id_read1,
    input  reg_idx_t id_read2,
    output logic     hazard_stall
);

    // A load targeting XZR produces nothing to wait for, so it is excluded.
    always_comb begin
        hazard_stall = ex_valid && ex_mem_read && (ex_rd != XZR) && id_valid &&
                       ((ex_rd == id_read1) || (ex_rd == id_read2));
    end

endmodule : id_ex_hazard

// File: rtl/id_ex_stage.sv
// ID/EX register with same-cycle writeback bypass, XZR forcing and load-use bubble insertion.
// Latency: one cycle from ID inputs to ex_*; hazard_stall is combinational.
// Backpressure: stall_in holds EX (flush overrides it); hazard_stall holds upstream while a bubble enters EX.
// Optional feature: define ID_EX_PERF_CNT_EN to add saturating bubble/stall performance counters.
module id_ex_stage
    import legv8_pkg::*;
#(
    parameter int       CTRL_W = CTRL_W_DEFAULT,
    parameter reg_idx_t XZR    = XZR_IDX
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  reg_idx_t          id_read1,
    input  reg_idx_t          id_read2,
    input  dword_t            id_data1,
    input  dword_t            id_data2,
    input  reg_idx_t          id_rd,
    input  dword_t            id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              wb_reg_write,
    input  reg_idx_t          wb_write_reg,
    input  dword_t            wb_write_data,
    input  logic              stall_in,
    input  logic              flush,
    output logic              hazard_stall,
    output logic              ex_valid,
    output dword_t            ex_op1,
    output dword_t            ex_op2,
    output dword_t            ex_imm,
    output reg_idx_t          ex_rd,
    output reg_idx_t          ex_rs1,
    output reg_idx_t          ex_rs2,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    logic              ex_valid_q, ex_valid_d;
    dword_t            ex_op1_q,   ex_op1_d;
    dword_t            ex_op2_q,   ex_op2_d;
    dword_t            ex_imm_q,   ex_imm_d;
    reg_idx_t          ex_rd_q,    ex_rd_d;
    reg_idx_t          ex_rs1_q,   ex_rs1_d;
    reg_idx_t          ex_rs2_q,   ex_rs2_d;
    logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
    logic              ex_mem_read_q, ex_mem_read_d;

    dword_t op1_sel;
    dword_t op2_sel;
    logic   bubble_ins;
    logic   stall_hold;

    id_ex_hazard #(
        .XZR (XZR)
    ) u_hazard (
        .ex_valid     (ex_valid_q),
        .ex_mem_read  (ex_mem_read_q),
        .ex_rd        (ex_rd_q),
        .id_valid     (id_valid),
        .id_read1     (id_read1),
        .id_read2     (id_read2),
        .hazard_stall (hazard_stall)
    );

    // Operand muxes: XZR reads zero; otherwise take the value being written this edge,
    // since the register file still returns the old contents during the write cycle.
    always_comb begin
        op1_sel = id_data1;
        op2_sel = id_data2;
        if (id_read1 == XZR) begin
            op1_sel = '0;
        end else if (wb_reg_write && (wb_write_reg == id_read1) && (wb_write_reg != XZR)) begin
            op1_sel = wb_write_data;
        end
        if (id_read2 == XZR) begin
            op2_sel = '0;
        end else if (wb_reg_write && (wb_write_reg == id_read2) && (wb_write_reg != XZR)) begin
            op2_sel = wb_write_data;
        end
    end

    // Next EX contents: flush beats stall_in, which beats the load-use bubble.
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_op1_d      = ex_op1_q;
        ex_op2_d      = ex_op2_q;
        ex_imm_d      = ex_imm_q;
        ex_rd_d       = ex_rd_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_ctrl_d     = ex_ctrl_q;
        ex_mem_read_d = ex_mem_read_q;
        stall_hold    = 1'b0;
        bubble_ins    = 1'b0;
        if (flush || (!stall_in && hazard_stall)) begin
            bubble_ins    = !flush;
            ex_valid_d    = 1'b0;
            ex_op1_d      = '0;
            ex_op2_d      = '0;
            ex_imm_d      = '0;
            ex_rd_d       = XZR;
            ex_rs1_d      = XZR;
            ex_rs2_d      = XZR;
            ex_ctrl_d     = '0;
            ex_mem_read_d = 1'b0;
        end else if (stall_in) begin
            stall_hold    = 1'b1;
        end else begin
            ex_valid_d    = id_valid;
            ex_op1_d      = op1_sel;
            ex_op2_d      = op2_sel;
            ex_imm_d      = id_imm;
            ex_rd_d       = id_rd;
            ex_rs1_d      = id_read1;
            ex_rs2_d      = id_read2;
            ex_ctrl_d     = id_ctrl;
            ex_mem_read_d = id_mem_read;
        end
    end

    // EX pipeline register; reset loads the bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            ex_op1_q      <= '0;
            ex_op2_q      <= '0;
            ex_imm_q      <= '0;
            ex_rd_q       <= XZR;
            ex_rs1_q      <= XZR;
            ex_rs2_q      <= XZR;
            ex_ctrl_q     <= '0;
            ex_mem_read_q <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_op1_q      <= ex_op1_d;
            ex_op2_q      <= ex_op2_d;
            ex_imm_q      <= ex_imm_d;
            ex_rd_q       <= ex_rd_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_mem_read_q <= ex_mem_read_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_op1      = ex_op1_q;
    assign ex_op2      = ex_op2_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rd       = ex_rd_q;
    assign ex_rs1      = ex_rs1_q;
    assign ex_rs2      = ex_rs2_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign ex_mem_read = ex_mem_read_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt_q, perf_bubble_cnt_d;
    logic [31:0] perf_stall_cnt_q,  perf_stall_cnt_d;

    // Saturating event counters: load-use bubbles and cycles held by stall_in.
    always_comb begin
        perf_bubble_cnt_d = perf_bubble_cnt_q;
        perf_stall_cnt_d  = perf_stall_cnt_q;
        if (bubble_ins && (perf_bubble_cnt_q != 32'hFFFF_FFFF)) begin
            perf_bubble_cnt_d = perf_bubble_cnt_q + 32'd1;
        end
        if (stall_hold && (perf_stall_cnt_q != 32'hFFFF_FFFF)) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_bubble_cnt_q <= '0;
            perf_stall_cnt_q  <= '0;
        end else begin
            perf_bubble_cnt_q <= perf_bubble_cnt_d;
            perf_stall_cnt_q  <= perf_stall_cnt_d;
        end
    end

    assign perf_bubble_cnt = perf_bubble_cnt_q;
    assign perf_stall_cnt  = perf_stall_cnt_q;
`else
    logic unused_ok;
    assign unused_ok = bubble_ins ^ stall_hold;
`endif

endmodule : id_ex_stage
